etapa_if_id: RTL and testbench
==============================

# etapa_if_id

Instruction-fetch stage of the MIPS pipeline: PC register, synchronous instruction memory and IF/ID pipeline register in one block. It consumes the bubble bit produced by the hazard detection unit and the branch/jump redirect resolved in ID. It delivers the instruction and PC+1 to the decode stage. It also hosts the program-load write port driven by the debug unit and flags the HALT instruction.

## Interface
- CANT_BITS_ADDR, 11: instruction-memory address width; word addressed, 2^11 words.
- CANT_BITS_INSTRUCCION, 32: instruction width.
- HALT_OPCODE, 32'hFFFFFFFF: encoding of the HALT instruction.
- i_clock  in  1  single clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  debug-unit run/step enable; 0 freezes PC, IF/ID and halt flag.
- i_bit_burbuja  in  1  stall request from hazard detection unit.
- i_branch_taken  in  1  ID resolved a taken branch or jump.
- i_branch_addr  in  CANT_BITS_ADDR  redirect target (word address).
- i_wr_mem  in  1  program-load write strobe.
- i_addr_mem_load  in  CANT_BITS_ADDR  program-load address.
- i_dato_mem_load  in  CANT_BITS_INSTRUCCION  program-load data.
- o_instruccion  out  CANT_BITS_INSTRUCCION  IF/ID instruction; 0 (NOP) when not valid.
- o_pc_mas_uno  out  CANT_BITS_ADDR  IF/ID PC+1 of that instruction.
- o_valid  out  1  IF/ID holds a real fetched instruction.
- o_pc  out  CANT_BITS_ADDR  current PC, for the debug unit.
- o_halt  out  1  sticky: HALT has entered IF/ID.

## Operation
- Reset (async): PC=0, o_valid=0, o_instruccion=0, o_pc_mas_uno=0, o_halt=0. Memory contents are not cleared.
- Each enabled edge selects one action. Priority, highest first: reset, !i_enable, halted, i_bit_burbuja, i_branch_taken, normal.
- !i_enable: all registers hold. Memory writes via i_wr_mem still occur.
- i_bit_burbuja: PC and IF/ID (instruction, PC+1, valid) hold. A simultaneous i_branch_taken is ignored; ID re-resolves it next cycle with forwarded data.
- i_branch_taken (no bubble): PC <= i_branch_addr. IF/ID <= flushed: o_valid=0, output NOP, o_pc_mas_uno=0. No delay slot.
- Normal: IF/ID <= {mem[PC], PC+1, valid=1}; PC <= PC+1.
- PC+1 wraps modulo 2^CANT_BITS_ADDR; 2047+1 = 0.
- Halt:
  - When the word being latched valid into IF/ID equals HALT_OPCODE, o_halt sets on that edge.
  - From the next edge on, PC holds and IF/ID loads NOP/valid=0, so HALT is presented exactly one cycle and then drains.
  - A flushed HALT never sets o_halt. Only reset clears it.
- Program load:
  - Memory write port is independent of the fetch port.
  - A write to the address being read on the same edge returns old data (read-first).

## Timing
- Fetch latency: one cycle. PC=p at edge k gives mem[p] on o_instruccion after edge k+1.
- Branch penalty: one bubble (the flushed slot).
- Stall: each cycle of i_bit_burbuja=1 adds one cycle with identical IF/ID outputs.
- Outputs are all registered; no combinational path from inputs to outputs.
- Reset mid-stream: outputs go to reset values immediately (async). First valid instruction appears one edge after reset deasserts, at mem[0].

## Structure
- Shared MIPS package (existing or new) holds: NOP encoding (0), HALT_OPCODE, CANT_BITS_INSTRUCCION, CANT_BITS_ADDR defaults.
- One sub-module: memoria_instrucciones.
  - Simple dual-port BRAM: write port for load, read port with read enable.
  - Registered output; read enable held low during stall/freeze.
  - The flush/valid mux sits in etapa_if_id.

## Test plan
- Reset, then mem[0..3]={A,B,C,D}, enable=1 → o_instruccion A,B,C,D on successive cycles; o_pc_mas_uno 1,2,3,4; o_valid=1.
- i_bit_burbuja=1 for 2 cycles while B in IF/ID → B held 3 cycles total, PC stays 2, then C, D follow.
- i_branch_taken=1, i_branch_addr=10 with B in IF/ID → next cycle o_valid=0, o_instruccion=0, then mem[10], o_pc_mas_uno=11.
- Same cycle i_bit_burbuja=1 and i_branch_taken=1 → stall wins, PC and IF/ID unchanged. Branch alone next cycle → redirect.
- mem[2]=32'hFFFFFFFF → HALT shown one cycle, o_halt=1 sticky, then o_valid=0 and o_pc=3 frozen. Assert i_reset mid-halt → all outputs 0.
- PC=2047 with normal fetch → o_pc_mas_uno=0 and next fetch from address 0. i_enable=0 for 3 cycles → every output constant.

Source files
------------

// File: rtl/etapa_if_id_pkg.sv
// Shared fetch-stage definitions: widths, special encodings and the per-edge action.
package etapa_if_id_pkg;
  localparam int CANT_BITS_ADDR        = 11;
  localparam int CANT_BITS_INSTRUCCION = 32;

  typedef logic [CANT_BITS_ADDR-1:0]        addr_t;
  typedef logic [CANT_BITS_INSTRUCCION-1:0] instr_t;

  localparam instr_t NOP         = '0;
  localparam instr_t HALT_OPCODE = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ACC_CONGELAR,
    ACC_DRENAR,
    ACC_BURBUJA,
    ACC_SALTO,
    ACC_FETCH
  } accion_t;

  typedef enum logic {
    EST_CORRIENDO,
    EST_DETENIDO
  } estado_t;

  function automatic logic es_halt(input instr_t palabra);
    return palabra == HALT_OPCODE;
  endfunction
endpackage

// File: rtl/etapa_if_id_if.sv
// Control, redirect, program-load and IF/ID signals of the fetch stage.
interface etapa_if_id_if;
  import etapa_if_id_pkg::*;

  logic   i_enable;
  logic   i_bit_burbuja;
  logic   i_branch_taken;
  addr_t  i_branch_addr;
  logic   i_wr_mem;
  addr_t  i_addr_mem_load;
  instr_t i_dato_mem_load;
  instr_t o_instruccion;
  addr_t  o_pc_mas_uno;
  logic   o_valid;
  addr_t  o_pc;
  logic   o_halt;

  modport master (
    output i_enable, i_bit_burbuja, i_branch_taken, i_branch_addr,
           i_wr_mem, i_addr_mem_load, i_dato_mem_load,
    input  o_instruccion, o_pc_mas_uno, o_valid, o_pc, o_halt
  );

  modport slave (
    input  i_enable, i_bit_burbuja, i_branch_taken, i_branch_addr,
           i_wr_mem, i_addr_mem_load, i_dato_mem_load,
    output o_instruccion, o_pc_mas_uno, o_valid, o_pc, o_halt
  );
endinterface

// File: rtl/etapa_if_id_memoria_instrucciones.sv
// Simple dual-port instruction BRAM: load write port, registered read port (read-first).
module etapa_if_id_memoria_instrucciones
  import etapa_if_id_pkg::*;
(
  input  logic   clk_sys,
  input  logic   wr_en,
  input  addr_t  wr_addr,
  input  instr_t wr_data,
  input  logic   rd_en,
  input  addr_t  rd_addr,
  output instr_t rd_data
);

  instr_t mem [2**CANT_BITS_ADDR];

  // Non-blocking read and write on the same edge gives old data on an address collision.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/etapa_if_id.sv
// MIPS fetch stage: PC, instruction memory and IF/ID register with stall, redirect and halt.
//
// state         | meaning
// EST_CORRIENDO | fetching normally
// EST_DETENIDO  | HALT has reached IF/ID; PC frozen, IF/ID drains to NOP
module etapa_if_id
  import etapa_if_id_pkg::*;
(
  input logic          i_clock,
  input logic          i_reset,
  etapa_if_id_if.slave bus
);

  estado_t estado_q, estado_d;
  accion_t accion;
  addr_t   pc_q, pc_d;
  addr_t   pc_mas_uno_q, pc_mas_uno_d;
  logic    valid_q, valid_d;
  instr_t  rd_data;
  logic    halt_en_ifid;

  // The BRAM output register doubles as the IF/ID instruction register.
  etapa_if_id_memoria_instrucciones u_mem (
    .clk_sys (i_clock),
    .wr_en   (bus.i_wr_mem),
    .wr_addr (bus.i_addr_mem_load),
    .wr_data (bus.i_dato_mem_load),
    .rd_en   (accion == ACC_FETCH),
    .rd_addr (pc_q),
    .rd_data (rd_data)
  );

  assign halt_en_ifid = valid_q && es_halt(rd_data);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      estado_q     <= EST_CORRIENDO;
      pc_q         <= '0;
      pc_mas_uno_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      pc_q         <= pc_d;
      pc_mas_uno_q <= pc_mas_uno_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    accion       = ACC_CONGELAR;
    estado_d     = estado_q;
    pc_d         = pc_q;
    pc_mas_uno_d = pc_mas_uno_q;
    valid_d      = valid_q;

    if (!bus.i_enable)                                  accion = ACC_CONGELAR;
    else if (estado_q == EST_DETENIDO || halt_en_ifid)  accion = ACC_DRENAR;
    else if (bus.i_bit_burbuja)                         accion = ACC_BURBUJA;
    else if (bus.i_branch_taken)                        accion = ACC_SALTO;
    else                                                accion = ACC_FETCH;

    unique case (accion)
      ACC_DRENAR: begin
        estado_d     = EST_DETENIDO;
        pc_mas_uno_d = '0;
        valid_d      = 1'b0;
      end
      ACC_SALTO: begin
        pc_d         = bus.i_branch_addr;
        pc_mas_uno_d = '0;
        valid_d      = 1'b0;
      end
      ACC_FETCH: begin
        pc_d         = pc_q + addr_t'(1);
        pc_mas_uno_d = pc_q + addr_t'(1);
        valid_d      = 1'b1;
      end
      default: ;
    endcase
  end

  // Stale BRAM data is masked whenever the slot is not a real fetch.
  assign bus.o_instruccion = valid_q ? rd_data : NOP;
  assign bus.o_pc_mas_uno  = pc_mas_uno_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_pc          = pc_q;
  assign bus.o_halt        = (estado_q == EST_DETENIDO) || halt_en_ifid;

endmodule

// File: tb/tb_etapa_if_id.sv
// Fetch-stage bench: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_etapa_if_id;
  import etapa_if_id_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  etapa_if_id_if bus();

  etapa_if_id dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: memory array plus the architectural IF/ID contents.
  logic [31:0] m_mem [0:2047];
  int unsigned m_pc, m_pmu;
  logic [31:0] m_instr;
  logic        m_valid, m_halt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 0; m_pmu = 0; m_instr = 0; m_valid = 0; m_halt = 0;
    end else begin
      logic [31:0] leida;
      leida = m_mem[m_pc];
      if (bus.i_enable) begin
        if (m_halt) begin
          m_valid = 0; m_instr = 0; m_pmu = 0;
        end else if (bus.i_bit_burbuja) begin
        end else if (bus.i_branch_taken) begin
          m_pc = bus.i_branch_addr; m_valid = 0; m_instr = 0; m_pmu = 0;
        end else begin
          m_instr = leida;
          m_valid = 1;
          m_pmu   = (m_pc + 1) % 2048;
          m_pc    = m_pmu;
          if (leida == 32'hFFFF_FFFF) m_halt = 1;
        end
      end
      if (bus.i_wr_mem) m_mem[bus.i_addr_mem_load] = bus.i_dato_mem_load;
    end
  end

  task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nombre, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("instr",  bus.o_instruccion,       m_instr);
    chk("pmu",    32'(bus.o_pc_mas_uno),   m_pmu);
    chk("valid",  32'(bus.o_valid),        32'(m_valid));
    chk("pc",     32'(bus.o_pc),           m_pc);
    chk("halt",   32'(bus.o_halt),         32'(m_halt));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wr_word(input int unsigned a, input logic [31:0] d);
    bus.i_wr_mem = 1; bus.i_addr_mem_load = addr_t'(a); bus.i_dato_mem_load = d;
    tick(1);
    bus.i_wr_mem = 0;
  endtask

  task automatic do_reset();
    rst = 1; #1; rst = 0;
  endtask

  task automatic lit(input string n, input logic [31:0] instr, input int unsigned pmu,
                     input logic valid, input int unsigned pc, input logic halt);
    chk({n, "_instr"}, bus.o_instruccion,     instr);
    chk({n, "_pmu"},   32'(bus.o_pc_mas_uno), pmu);
    chk({n, "_valid"}, 32'(bus.o_valid),      32'(valid));
    chk({n, "_pc"},    32'(bus.o_pc),         pc);
    chk({n, "_halt"},  32'(bus.o_halt),       32'(halt));
  endtask

  localparam logic [31:0] A = 32'h1111_0001, B = 32'h2222_0002, C = 32'h3333_0003;
  localparam logic [31:0] D = 32'h4444_0004, K = 32'h5555_000A, W = 32'h7777_07FF;
  localparam logic [31:0] N = 32'h6666_1234, H = 32'hFFFF_FFFF;

  initial begin
    bus.i_enable = 0; bus.i_bit_burbuja = 0; bus.i_branch_taken = 0; bus.i_branch_addr = '0;
    bus.i_wr_mem = 0; bus.i_addr_mem_load = '0; bus.i_dato_mem_load = '0;
    #1 rst = 1;
    @(negedge clk); #1;
    lit("reset", 0, 0, 0, 0, 0);
    rst = 0;

    for (int i = 0; i < 2048; i++) begin
      logic [31:0] d;
      d = $urandom;
      if (d == H) d = 0;
      wr_word(i, d);
    end
    wr_word(0, A); wr_word(1, B); wr_word(2, C); wr_word(3, D);
    wr_word(10, K); wr_word(2047, W);

    // Sequential fetch and stall.
    bus.i_enable = 1;
    tick(1); lit("seq_a", A, 1, 1, 1, 0);
    tick(1); lit("seq_b", B, 2, 1, 2, 0);
    bus.i_bit_burbuja = 1;
    tick(1); lit("stall1", B, 2, 1, 2, 0);
    tick(1); lit("stall2", B, 2, 1, 2, 0);
    bus.i_bit_burbuja = 0;
    tick(1); lit("seq_c", C, 3, 1, 3, 0);
    tick(1); lit("seq_d", D, 4, 1, 4, 0);

    // Taken branch with B in IF/ID.
    do_reset();
    tick(2); lit("br_b", B, 2, 1, 2, 0);
    bus.i_branch_taken = 1; bus.i_branch_addr = 11'd10;
    tick(1); lit("br_flush", 0, 0, 0, 10, 0);
    bus.i_branch_taken = 0;
    tick(1); lit("br_tgt", K, 11, 1, 11, 0);

    // Stall beats a simultaneous branch.
    do_reset();
    tick(2);
    bus.i_bit_burbuja = 1; bus.i_branch_taken = 1; bus.i_branch_addr = 11'd10;
    tick(1); lit("stbr_hold", B, 2, 1, 2, 0);
    bus.i_bit_burbuja = 0;
    tick(1); lit("stbr_flush", 0, 0, 0, 10, 0);
    bus.i_branch_taken = 0;
    tick(1); lit("stbr_tgt", K, 11, 1, 11, 0);

    // Load write to the address being fetched returns old data.
    do_reset();
    tick(1);
    bus.i_wr_mem = 1; bus.i_addr_mem_load = 11'd1; bus.i_dato_mem_load = N;
    tick(1); lit("rdfirst", B, 2, 1, 2, 0);
    bus.i_wr_mem = 0;

    // HALT at address 2, then async reset while halted.
    bus.i_enable = 0;
    wr_word(2, H);
    bus.i_enable = 1;
    do_reset();
    tick(1); lit("h_a", A, 1, 1, 1, 0);
    tick(1); lit("h_n", N, 2, 1, 2, 0);
    tick(1); lit("h_halt", H, 3, 1, 3, 1);
    tick(1); lit("h_drain", 0, 0, 0, 3, 1);
    tick(1); lit("h_frozen", 0, 0, 0, 3, 1);
    rst = 1; #1;
    lit("h_rst", 0, 0, 0, 0, 0);
    tick(1);
    rst = 0;
    bus.i_enable = 0;
    wr_word(2, C);
    bus.i_enable = 1;

    // PC wrap from 2047 to 0.
    do_reset();
    bus.i_branch_taken = 1; bus.i_branch_addr = 11'd2047;
    tick(1); lit("wr_flush", 0, 0, 0, 2047, 0);
    bus.i_branch_taken = 0;
    tick(1); lit("wr_top", W, 0, 1, 0, 0);
    tick(1); lit("wr_zero", A, 1, 1, 1, 0);

    // Freeze holds everything.
    bus.i_enable = 0;
    tick(1); lit("frz1", A, 1, 1, 1, 0);
    tick(1); lit("frz2", A, 1, 1, 1, 0);
    tick(1); lit("frz3", A, 1, 1, 1, 0);
    bus.i_enable = 1;

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      bus.i_enable       = ($urandom_range(0, 9) != 0);
      bus.i_bit_burbuja  = ($urandom_range(0, 4) == 0);
      bus.i_branch_taken = ($urandom_range(0, 6) == 0);
      bus.i_branch_addr  = addr_t'($urandom_range(0, 2047));
      bus.i_wr_mem       = ($urandom_range(0, 9) == 0);
      bus.i_addr_mem_load = ($urandom_range(0, 1) == 0) ? addr_t'(m_pc) : addr_t'($urandom_range(0, 2047));
      bus.i_dato_mem_load = ($urandom_range(0, 29) == 0) ? H : $urandom;
      if ($urandom_range(0, 49) == 0) begin
        rst = 1; #1; rst = 0;
      end
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
